// File: rtl/rr_decode_arbiter.sv
// Round-robin arbiter for 2**N requesters: registered index/one-hot grant,
// bounded hold time and a one-cycle turnaround gap between owners.
module rr_decode_arbiter #(
    parameter int N        = 3,
    parameter int REQS     = 2**N,   // derived; do not override
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REQS-1:0] req,
    output logic [REQS-1:0] gnt,
    output logic [N-1:0]    gnt_idx,
    output logic            gnt_valid,
    output logic            timeout
);

    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

    state_t          state_q;
    logic [REQS-1:0] gnt_q;
    logic [N-1:0]    gnt_idx_q;
    logic            gnt_valid_q;
    logic            timeout_q;
    logic [HW-1:0]   hold_cnt_q;
    logic [N-1:0]    last_idx_q;

    logic [N-1:0]    pick;
    logic [N-1:0]    cand;
    logic            found;
    logic            owner_req;
    logic            hold_expired;

    // Search upward from last_idx+1; the N-bit add provides the wrap.
    always_comb begin
        pick  = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 1; k <= REQS; k++) begin
            cand = last_idx_q + N'(k);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
    end

    assign owner_req    = req[gnt_idx_q];
    assign hold_expired = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

    function automatic logic [REQS-1:0] decode(input logic [N-1:0] idx);
        decode      = '0;
        decode[idx] = 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            hold_cnt_q  <= '0;
            last_idx_q  <= '1;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE, GAP: begin
                    if (found) begin
                        state_q     <= GRANT;
                        gnt_q       <= decode(pick);
                        gnt_idx_q   <= pick;
                        gnt_valid_q <= 1'b1;
                        last_idx_q  <= pick;
                        hold_cnt_q  <= '0;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                GRANT: begin
                    // Forced release leaves last_idx at the old owner so it is searched last.
                    if (!owner_req || hold_expired) begin
                        state_q     <= GAP;
                        gnt_q       <= '0;
                        gnt_idx_q   <= '0;
                        gnt_valid_q <= 1'b0;
                        hold_cnt_q  <= '0;
                        timeout_q   <= owner_req;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt       = gnt_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule
